// File: rtl/dram_cmd_scheduler_pkg.sv
// dram_sched_pkg: shared types and defaults for the DRAM command scheduler.
//   cmd_t    - 3-bit PHY command encoding (NOP/ACT/PRE/RD/WR/REF/PREA)
//   state_t  - scheduler FSM states (refresh states unused unless REFRESH_EN)
//   DEF_*    - default timing values in clock cycles
//   NUM_BANKS, max2() helper for counter sizing
package dram_sched_pkg;

  localparam int unsigned NUM_BANKS   = 16;
  localparam int unsigned DEF_T_RCD   = 4;
  localparam int unsigned DEF_T_RP    = 4;
  localparam int unsigned DEF_T_RAS   = 10;
  localparam int unsigned DEF_T_CCD   = 2;
  localparam int unsigned DEF_T_REFI  = 1560;
  localparam int unsigned DEF_T_RFC   = 40;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_RD   = 3'd3,
    CMD_WR   = 3'd4,
    CMD_REF  = 3'd5,
    CMD_PREA = 3'd6
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECIDE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_PREA,
    S_WAIT_RPA,
    S_REF,
    S_WAIT_RFC
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_cmd_scheduler_bank_table.sv
// bank_table: per-bank open flag, open row and tRAS down-counter (16 banks,
// indexed {bg,ba}).
//   lk_idx/lk_row   -> lk_open, lk_hit, lk_tras_near (lookup of one bank)
//   any_open, all_tras_zero -> whole-table status used by refresh
//   act_en/act_idx/act_row  -> open a row, load tRAS
//   pre_en/pre_idx          -> close one bank
//   prea_en                 -> close all banks
module bank_table
  import dram_sched_pkg::*;
#(
  parameter int unsigned RA_BITS = 16,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned T_RAS   = DEF_T_RAS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         lk_idx,
  input  logic [RA_BITS-1:0] lk_row,
  output logic               lk_open,
  output logic               lk_hit,
  output logic               lk_tras_near,
  output logic               any_open,
  output logic               all_tras_zero,
  input  logic               act_en,
  input  logic [3:0]         act_idx,
  input  logic [RA_BITS-1:0] act_row,
  input  logic               pre_en,
  input  logic [3:0]         pre_idx,
  input  logic               prea_en
);

  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [RA_BITS-1:0]   row_q  [NUM_BANKS];
  logic [RA_BITS-1:0]   row_d  [NUM_BANKS];
  logic [CNT_W-1:0]     tras_q [NUM_BANKS];
  logic [CNT_W-1:0]     tras_d [NUM_BANKS];

  always_comb begin
    open_d = open_q;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      row_d[i]  = row_q[i];
      tras_d[i] = (tras_q[i] != '0) ? tras_q[i] - 1'b1 : '0;
    end
    if (pre_en)  open_d[pre_idx] = 1'b0;
    if (prea_en) open_d = '0;
    if (act_en) begin
      open_d[act_idx] = 1'b1;
      row_d[act_idx]  = act_row;
      tras_d[act_idx] = CNT_W'(T_RAS - 1);
    end
  end

  always_comb begin
    lk_open       = open_q[lk_idx];
    lk_hit        = open_q[lk_idx] && (row_q[lk_idx] == lk_row);
    // The PRE leaves one cycle after the decision, so a count of 1 here
    // has already expired by the time the command is on the bus.
    lk_tras_near  = (tras_q[lk_idx] <= CNT_W'(1));
    any_open      = |open_q;
    all_tras_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (tras_q[i] != '0) all_tras_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        row_q[i]  <= '0;
        tras_q[i] <= '0;
      end
    end else begin
      open_q <= open_d;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        row_q[i]  <= row_d[i];
        tras_q[i] <= tras_d[i];
      end
    end
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: turns one granted request at a time into a legal
// ACT/PRE/RD/WR sequence, enforcing tRCD, tRP, tRAS and tCCD.
// Optional periodic refresh (PREA/REF) is built when REFRESH_EN is defined.
//   req_*  : request handshake and fields (latched on acceptance)
//   cmd_*  : registered PHY command port; cmd=NOP when cmd_valid=0,
//            address/data/index fields hold their last value
module dram_cmd_scheduler
  import dram_sched_pkg::*;
#(
  parameter int unsigned RA_BITS    = 16,
  parameter int unsigned CA_BITS    = 10,
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned T_RCD      = DEF_T_RCD,
  parameter int unsigned T_RP       = DEF_T_RP,
  parameter int unsigned T_RAS      = DEF_T_RAS,
  parameter int unsigned T_CCD      = DEF_T_CCD,
  parameter int unsigned T_REFI     = DEF_T_REFI,
  parameter int unsigned T_RFC      = DEF_T_RFC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_type,
  input  logic [RA_BITS-1:0]    req_row,
  input  logic [CA_BITS-1:0]    req_col,
  input  logic [1:0]            req_ba,
  input  logic [1:0]            req_bg,
  input  logic [DATA_BITS-1:0]  req_data,
  input  logic [INDEX_BITS-1:0] req_idx,
  output logic                  cmd_valid,
  output logic [2:0]            cmd,
  output logic [1:0]            cmd_ba,
  output logic [1:0]            cmd_bg,
  output logic [RA_BITS-1:0]    cmd_addr,
  output logic [DATA_BITS-1:0]  cmd_data,
  output logic [INDEX_BITS-1:0] cmd_idx
);

  localparam int unsigned T_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RAS, T_CCD)),
                                       max2(T_REFI, T_RFC));
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      phase_q, phase_d;
  logic [CNT_W-1:0]      tccd_q, tccd_d;
  logic                  ready_q, ready_d;

  logic                  rq_type_q, rq_type_d;
  logic [RA_BITS-1:0]    rq_row_q, rq_row_d;
  logic [CA_BITS-1:0]    rq_col_q, rq_col_d;
  logic [1:0]            rq_ba_q, rq_ba_d;
  logic [1:0]            rq_bg_q, rq_bg_d;
  logic [DATA_BITS-1:0]  rq_data_q, rq_data_d;
  logic [INDEX_BITS-1:0] rq_idx_q, rq_idx_d;

  cmd_t                  cmd_q, cmd_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [1:0]            cmd_ba_q, cmd_ba_d;
  logic [1:0]            cmd_bg_q, cmd_bg_d;
  logic [RA_BITS-1:0]    cmd_addr_q, cmd_addr_d;
  logic [DATA_BITS-1:0]  cmd_data_q, cmd_data_d;
  logic [INDEX_BITS-1:0] cmd_idx_q, cmd_idx_d;

  logic                  lk_open, lk_hit, lk_tras_near;
  logic                  any_open, all_tras_zero;
  logic                  act_en, pre_en, prea_en;
  logic [3:0]            rq_bank;

`ifdef REFRESH_EN
  logic [CNT_W-1:0]      refi_q, refi_d;
  logic                  ref_pend_q, ref_pend_d;
`else
  logic                  unused_ref_status;
  assign unused_ref_status = any_open ^ all_tras_zero;
`endif

  assign rq_bank = {rq_bg_q, rq_ba_q};

  bank_table #(
    .RA_BITS (RA_BITS),
    .CNT_W   (CNT_W),
    .T_RAS   (T_RAS)
  ) u_bank_table (
    .clk           (clk),
    .rst           (rst),
    .lk_idx        (rq_bank),
    .lk_row        (rq_row_q),
    .lk_open       (lk_open),
    .lk_hit        (lk_hit),
    .lk_tras_near  (lk_tras_near),
    .any_open      (any_open),
    .all_tras_zero (all_tras_zero),
    .act_en        (act_en),
    .act_idx       (rq_bank),
    .act_row       (rq_row_q),
    .pre_en        (pre_en),
    .pre_idx       (rq_bank),
    .prea_en       (prea_en)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = (phase_q != '0) ? phase_q - 1'b1 : '0;
    tccd_d      = (tccd_q != '0) ? tccd_q - 1'b1 : '0;
    rq_type_d   = rq_type_q;
    rq_row_d    = rq_row_q;
    rq_col_d    = rq_col_q;
    rq_ba_d     = rq_ba_q;
    rq_bg_d     = rq_bg_q;
    rq_data_d   = rq_data_q;
    rq_idx_d    = rq_idx_q;
    cmd_d       = CMD_NOP;
    cmd_valid_d = 1'b0;
    cmd_ba_d    = cmd_ba_q;
    cmd_bg_d    = cmd_bg_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_idx_d   = cmd_idx_q;
    act_en      = 1'b0;
    pre_en      = 1'b0;
    prea_en     = 1'b0;
`ifdef REFRESH_EN
    refi_d      = (refi_q == CNT_W'(T_REFI - 1)) ? '0 : refi_q + 1'b1;
    ref_pend_d  = ref_pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          rq_type_d = req_type;
          rq_row_d  = req_row;
          rq_col_d  = req_col;
          rq_ba_d   = req_ba;
          rq_bg_d   = req_bg;
          rq_data_d = req_data;
          rq_idx_d  = req_idx;
          state_d   = S_DECIDE;
        end
`ifdef REFRESH_EN
        else if (ref_pend_q) begin
          state_d = any_open ? S_PREA : S_REF;
        end
`endif
      end
      S_DECIDE: begin
        if (lk_hit)            state_d = S_CAS;
        else if (!lk_open)     state_d = S_ACT;
        else if (lk_tras_near) state_d = S_PRE;
      end
      S_PRE: begin
        cmd_d       = CMD_PRE;
        cmd_valid_d = 1'b1;
        cmd_ba_d    = rq_ba_q;
        cmd_bg_d    = rq_bg_q;
        pre_en      = 1'b1;
        phase_d     = CNT_W'(T_RP - 2);
        state_d     = S_WAIT_RP;
      end
      S_WAIT_RP: begin
        if (phase_q == '0) state_d = S_ACT;
      end
      S_ACT: begin
        cmd_d       = CMD_ACT;
        cmd_valid_d = 1'b1;
        cmd_ba_d    = rq_ba_q;
        cmd_bg_d    = rq_bg_q;
        cmd_addr_d  = rq_row_q;
        act_en      = 1'b1;
        phase_d     = CNT_W'(T_RCD - 2);
        state_d     = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (phase_q == '0) state_d = S_CAS;
      end
      S_CAS: begin
        if (tccd_q == '0) begin
          cmd_d       = rq_type_q ? CMD_WR : CMD_RD;
          cmd_valid_d = 1'b1;
          cmd_ba_d    = rq_ba_q;
          cmd_bg_d    = rq_bg_q;
          cmd_addr_d  = RA_BITS'(rq_col_q);
          cmd_data_d  = rq_data_q;
          cmd_idx_d   = rq_idx_q;
          tccd_d      = CNT_W'(T_CCD - 1);
          state_d     = S_IDLE;
        end
      end
`ifdef REFRESH_EN
      S_PREA: begin
        if (all_tras_zero) begin
          cmd_d       = CMD_PREA;
          cmd_valid_d = 1'b1;
          prea_en     = 1'b1;
          phase_d     = CNT_W'(T_RP - 2);
          state_d     = S_WAIT_RPA;
        end
      end
      S_WAIT_RPA: begin
        if (phase_q == '0) state_d = S_REF;
      end
      S_REF: begin
        cmd_d       = CMD_REF;
        cmd_valid_d = 1'b1;
        ref_pend_d  = 1'b0;
        // IDLE is re-entered exactly T_RFC cycles after REF.
        phase_d     = CNT_W'(T_RFC - 1);
        state_d     = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        if (phase_q == '0) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef REFRESH_EN
    if (refi_q == CNT_W'(T_REFI - 1)) ref_pend_d = 1'b1;
    ready_d = (state_d == S_IDLE) && !ref_pend_d;
`else
    ready_d = (state_d == S_IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      tccd_q      <= '0;
      ready_q     <= 1'b0;
      rq_type_q   <= 1'b0;
      rq_row_q    <= '0;
      rq_col_q    <= '0;
      rq_ba_q     <= '0;
      rq_bg_q     <= '0;
      rq_data_q   <= '0;
      rq_idx_q    <= '0;
      cmd_q       <= CMD_NOP;
      cmd_valid_q <= 1'b0;
      cmd_ba_q    <= '0;
      cmd_bg_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_idx_q   <= '0;
`ifdef REFRESH_EN
      refi_q      <= '0;
      ref_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tccd_q      <= tccd_d;
      ready_q     <= ready_d;
      rq_type_q   <= rq_type_d;
      rq_row_q    <= rq_row_d;
      rq_col_q    <= rq_col_d;
      rq_ba_q     <= rq_ba_d;
      rq_bg_q     <= rq_bg_d;
      rq_data_q   <= rq_data_d;
      rq_idx_q    <= rq_idx_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_idx_q   <= cmd_idx_d;
`ifdef REFRESH_EN
      refi_q      <= refi_d;
      ref_pend_q  <= ref_pend_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_idx   = cmd_idx_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench for dram_cmd_scheduler: table of requests with their
// expected bank outcome; expected commands and cycles are queued at
// handshake and compared as the DUT emits them.
module tb_dram_cmd_scheduler;
  import dram_sched_pkg::*;

  localparam int RA = 16, CA = 10, DB = 16, IB = 7;
  localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, T_CCD = 2, T_RFC = 40;
`ifdef REFRESH_EN
  localparam int T_REFI = 100;
`else
  localparam int T_REFI = 1560;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_type = 1'b0;
  logic [RA-1:0] req_row = '0;
  logic [CA-1:0] req_col = '0;
  logic [1:0]    req_ba = '0, req_bg = '0;
  logic [DB-1:0] req_data = '0;
  logic [IB-1:0] req_idx = '0;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [1:0]    cmd_ba, cmd_bg;
  logic [RA-1:0] cmd_addr;
  logic [DB-1:0] cmd_data;
  logic [IB-1:0] cmd_idx;

  dram_cmd_scheduler #(
    .RA_BITS(RA), .CA_BITS(CA), .DATA_BITS(DB), .INDEX_BITS(IB),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_CCD(T_CCD),
    .T_REFI(T_REFI), .T_RFC(T_RFC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_row(req_row), .req_col(req_col),
    .req_ba(req_ba), .req_bg(req_bg), .req_data(req_data), .req_idx(req_idx),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba), .cmd_bg(cmd_bg),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_idx(cmd_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef enum int {K_HIT, K_CLOSED, K_CONFLICT} kind_t;

  typedef struct {
    logic          typ;
    logic [1:0]    bg;
    logic [1:0]    ba;
    logic [RA-1:0] row;
    logic [CA-1:0] col;
    logic [DB-1:0] data;
    logic [IB-1:0] idx;
    kind_t         kind;
  } vec_t;

  typedef struct {
    int            cycle;
    logic [2:0]    cmd;
    logic [1:0]    ba;
    logic [1:0]    bg;
    logic [RA-1:0] addr;
    bit            chk_addr;
    logic [DB-1:0] data;
    logic [IB-1:0] idx;
    bit            chk_di;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b1;
  int   last_cas_seen = -100;
  int   last_cas_exp = -100;
  int   act_cyc[16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Command monitor: every emitted command must be the head of the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en && !rst) begin
      total++;
      if (cmd_valid) begin
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cmd: got cmd=%0d at cycle %0d, required none", cmd, cyc);
        end else begin
          e = q.pop_front();
          if (cyc != e.cycle || cmd != e.cmd || cmd_ba != e.ba || cmd_bg != e.bg ||
              (e.chk_addr && cmd_addr != e.addr) ||
              (e.chk_di && (cmd_data != e.data || cmd_idx != e.idx))) begin
            bad++;
            $display("FAIL cmd_check: got cyc=%0d cmd=%0d bg=%0d ba=%0d addr=%0h data=%0h idx=%0h required cyc=%0d cmd=%0d bg=%0d ba=%0d addr=%0h data=%0h idx=%0h",
                     cyc, cmd, cmd_bg, cmd_ba, cmd_addr, cmd_data, cmd_idx,
                     e.cycle, e.cmd, e.bg, e.ba, e.addr, e.data, e.idx);
          end
        end
        if (cmd == CMD_RD || cmd == CMD_WR) begin
          total++;
          if (cyc - last_cas_seen < 3) begin
            bad++;
            $display("FAIL cas_spacing: got %0d cycles required >= 3", cyc - last_cas_seen);
          end
          last_cas_seen = cyc;
        end
      end else if (cmd != CMD_NOP) begin
        bad++;
        $display("FAIL nop_when_idle: got cmd=%0d required 0", cmd);
      end
    end
  end

  task automatic push_exp(input int c, input logic [2:0] k, input logic [1:0] ba,
                          input logic [1:0] bg, input logic [RA-1:0] addr, input bit ca,
                          input logic [DB-1:0] data, input logic [IB-1:0] idx, input bit cdi);
    exp_t e;
    e.cycle = c; e.cmd = k; e.ba = ba; e.bg = bg; e.addr = addr; e.chk_addr = ca;
    e.data = data; e.idx = idx; e.chk_di = cdi;
    q.push_back(e);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) act_cyc[i] = -100;
    last_cas_exp  = -100;
    last_cas_seen = -100;
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send(input vec_t v);
    int n, w, b, act, pre, cas;
    logic [RA-1:0] col_ext;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got req_ready=0 required 1 within 200 cycles");
      return;
    end
    req_valid = 1'b1; req_type = v.typ; req_row = v.row; req_col = v.col;
    req_ba = v.ba; req_bg = v.bg; req_data = v.data; req_idx = v.idx;
    n = cyc + 1;
    b = int'({v.bg, v.ba});
    col_ext = '0;
    col_ext[CA-1:0] = v.col;
    case (v.kind)
      K_CLOSED: begin
        act = n + 2;
        push_exp(act, CMD_ACT, v.ba, v.bg, v.row, 1'b1, '0, '0, 1'b0);
        act_cyc[b] = act;
        cas = act + T_RCD;
      end
      K_CONFLICT: begin
        pre = (n + 2 > act_cyc[b] + T_RAS) ? n + 2 : act_cyc[b] + T_RAS;
        push_exp(pre, CMD_PRE, v.ba, v.bg, '0, 1'b0, '0, '0, 1'b0);
        act = pre + T_RP;
        push_exp(act, CMD_ACT, v.ba, v.bg, v.row, 1'b1, '0, '0, 1'b0);
        act_cyc[b] = act;
        cas = act + T_RCD;
      end
      default: cas = n + 2;
    endcase
    if (cas < last_cas_exp + T_CCD) cas = last_cas_exp + T_CCD;
    push_exp(cas, v.typ ? CMD_WR : CMD_RD, v.ba, v.bg, col_ext, 1'b1, v.data, v.idx, v.typ);
    last_cas_exp = cas;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, "_cmd"},       64'(cmd),       64'd0);
    check({tag, "_ba_bg"},     64'({cmd_bg, cmd_ba}), 64'd0);
    check({tag, "_addr"},      64'(cmd_addr),  64'd0);
    check({tag, "_data_idx"},  64'({cmd_data, cmd_idx}), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  vec_t vt[14];
  vec_t rv[3];

  initial begin
    int w, p, f;
    vt[0]  = '{1'b0, 2'd0, 2'd0, 16'h0012, 10'h005, 16'h0000, 7'h01, K_CLOSED};
    vt[1]  = '{1'b0, 2'd0, 2'd0, 16'h0012, 10'h007, 16'h0000, 7'h02, K_HIT};
    vt[2]  = '{1'b1, 2'd0, 2'd0, 16'h0034, 10'h009, 16'hBEEF, 7'h03, K_CONFLICT};
    vt[3]  = '{1'b0, 2'd1, 2'd1, 16'h0040, 10'h010, 16'h0000, 7'h04, K_CLOSED};
    vt[4]  = '{1'b0, 2'd2, 2'd2, 16'h0050, 10'h011, 16'h0000, 7'h05, K_CLOSED};
    vt[5]  = '{1'b0, 2'd3, 2'd3, 16'h0060, 10'h012, 16'h0000, 7'h06, K_CLOSED};
    vt[6]  = '{1'b0, 2'd0, 2'd1, 16'h0070, 10'h013, 16'h0000, 7'h07, K_CLOSED};
    vt[7]  = '{1'b1, 2'd1, 2'd1, 16'h0040, 10'h020, 16'h1111, 7'h08, K_HIT};
    vt[8]  = '{1'b1, 2'd2, 2'd2, 16'h0050, 10'h021, 16'h2222, 7'h09, K_HIT};
    vt[9]  = '{1'b1, 2'd3, 2'd3, 16'h0060, 10'h022, 16'h3333, 7'h0A, K_HIT};
    vt[10] = '{1'b0, 2'd0, 2'd1, 16'h0070, 10'h023, 16'h0000, 7'h0B, K_HIT};
    vt[11] = '{1'b0, 2'd1, 2'd1, 16'h0041, 10'h024, 16'h0000, 7'h0C, K_CONFLICT};
    vt[12] = '{1'b1, 2'd3, 2'd3, 16'h0060, 10'h3FF, 16'hFFFF, 7'h7F, K_HIT};
    vt[13] = '{1'b0, 2'd2, 2'd3, 16'hFFFF, 10'h000, 16'h0000, 7'h0D, K_CLOSED};
    rv[0]  = '{1'b0, 2'd2, 2'd0, 16'h0022, 10'h001, 16'h0000, 7'h20, K_CLOSED};
    rv[1]  = '{1'b1, 2'd0, 2'd0, 16'h0034, 10'h002, 16'hCAFE, 7'h21, K_CLOSED};
    rv[2]  = '{1'b0, 2'd3, 2'd3, 16'h0060, 10'h003, 16'h0000, 7'h22, K_CLOSED};
    reset_model();

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

`ifdef REFRESH_EN
    send(vt[0]);
    w = 0;
    while (q.size() != 0 && w < 100) begin @(negedge clk); w++; end
    check("refresh_setup_drain", 64'(q.size()), 64'd0);
    mon_en = 1'b0;
    w = 0;
    while (req_ready && w < 300) begin @(negedge clk); w++; end
    check("refresh_ready_drop", 64'(req_ready), 64'd0);
    w = 0;
    while (!cmd_valid && w < 50) begin @(negedge clk); w++; end
    check("refresh_prea", 64'(cmd), 64'(CMD_PREA));
    p = cyc;
    w = 0;
    do begin @(negedge clk); w++; end while (!cmd_valid && w < 20);
    check("refresh_ref", 64'(cmd), 64'(CMD_REF));
    check("refresh_ref_delay", 64'(cyc - p), 64'(T_RP));
    f = cyc;
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    check("refresh_ready_back", 64'(cyc - f), 64'(T_RFC));
`else
    for (int i = 0; i < 14; i++) send(vt[i]);

    // Reset while waiting out tRCD: RD must never appear, banks must close.
    send(rv[0]);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    check("ready_after_mid_reset", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) send(rv[i]);
`endif

    w = 0;
    while (q.size() != 0 && w < 200) begin @(negedge clk); w++; end
    check("queue_drained", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
